// File: rtl/vx_tma_xfer_ctrl_pkg.sv
// Shared types for the TMA element transfer controller: command record,
// FSM state encoding and the element-size clamp helper.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

package vx_tma_xfer_ctrl_pkg;

  localparam int TMA_ADDR_WIDTH = `MEM_ADDR_WIDTH;

  typedef struct packed {
    logic [TMA_ADDR_WIDTH-1:0] gbase;
    logic [TMA_ADDR_WIDTH-1:0] smem_base;
    logic [31:0]               coord0;
    logic [31:0]               coord1;
    logic [31:0]               size0;
    logic [31:0]               size1;
    logic [31:0]               stride0;
    logic [31:0]               tile0;
    logic [31:0]               total;
    logic [3:0]                elem_bytes;
    logic                      is_s2g;
  } tma_xfer_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_WAIT_WR = 3'd3,
    ST_DONE    = 3'd4
  } tma_xfer_state_t;

  function automatic logic [3:0] clamp_elem_bytes(input logic [3:0] eb, input logic [3:0] max_eb);
    return (eb > max_eb) ? max_eb : eb;
  endfunction

endpackage

// File: rtl/vx_tma_xfer_ctrl_addr_gen.sv
// Combinational address and bounds generation for one tile element.
// Works from the latched command fields plus the x/y/smem-offset counters.
module vx_tma_xfer_ctrl_addr_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] gbase,
  input  logic [ADDR_WIDTH-1:0] smem_base,
  input  logic [31:0]           coord0,
  input  logic [31:0]           coord1,
  input  logic [31:0]           size0,
  input  logic [31:0]           size1,
  input  logic [31:0]           stride0,
  input  logic [3:0]            elem_bytes,
  input  logic [31:0]           x,
  input  logic [31:0]           y,
  input  logic [ADDR_WIDTH-1:0] smem_off,
  output logic [ADDR_WIDTH-1:0] gmem_addr,
  output logic [ADDR_WIDTH-1:0] smem_addr,
  output logic                  in_bounds
);

  logic [31:0]           i0, i1;
  logic [ADDR_WIDTH-1:0] i0_w, i1_w, eb_w, stride_w;

  // element coordinates; both wrap modulo 2^32 before the unsigned bound test
  always_comb begin
    i0        = coord0 + x;
    i1        = coord1 + y;
    in_bounds = (i0 < size0) && (i1 < size1);
  end

  // addresses are formed at ADDR_WIDTH so the result simply wraps
  always_comb begin
    i0_w      = ADDR_WIDTH'(i0);
    i1_w      = ADDR_WIDTH'(i1);
    eb_w      = ADDR_WIDTH'(elem_bytes);
    stride_w  = ADDR_WIDTH'(stride0);
    gmem_addr = gbase + i0_w * eb_w + i1_w * stride_w;
    smem_addr = smem_base + smem_off;
  end

endmodule

// File: rtl/vx_tma_xfer_ctrl.sv
// TMA element transfer controller: walks a tile element by element, reading
// each in-bounds element from the source memory and writing it to the other.
// Optional performance counters are built when TMA_XFER_PERF_EN is defined.
//
// state      | meaning
// IDLE       | waiting for a command (cmd_ready high)
// ISSUE      | evaluate current element: done / read / zero-fill / skip
// WAIT_RD    | read accepted, waiting for rd_rsp_valid
// WAIT_WR    | write request pending until wr_req_ready
// DONE       | done_valid held until done_ready
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

module vx_tma_xfer_ctrl
  import vx_tma_xfer_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = `MEM_ADDR_WIDTH,
  parameter int MAX_ELEM_BYTES = 8,
  localparam int DW            = MAX_ELEM_BYTES * 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  tma_xfer_cmd_t         cmd_data,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  output logic                  rd_req_smem,
  output logic [3:0]            rd_req_bytes,
  input  logic                  rd_rsp_valid,
  input  logic [DW-1:0]         rd_rsp_data,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic                  wr_req_smem,
  output logic [3:0]            wr_req_bytes,
  output logic [DW-1:0]         wr_req_data,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  busy,
  output logic [31:0]           perf_elems,
  output logic [31:0]           perf_oob
);

  tma_xfer_state_t       state;
  tma_xfer_cmd_t         cmd_q;
  logic [31:0]           idx, x, y, x_nxt, y_nxt;
  logic [ADDR_WIDTH-1:0] smem_off, gmem_addr, smem_addr;
  logic [DW-1:0]         data_q, rsp_mask;
  logic                  in_bounds, wr_fire, skip_evt;

  vx_tma_xfer_ctrl_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .gbase      (ADDR_WIDTH'(cmd_q.gbase)),
    .smem_base  (ADDR_WIDTH'(cmd_q.smem_base)),
    .coord0     (cmd_q.coord0),
    .coord1     (cmd_q.coord1),
    .size0      (cmd_q.size0),
    .size1      (cmd_q.size1),
    .stride0    (cmd_q.stride0),
    .elem_bytes (cmd_q.elem_bytes),
    .x          (x),
    .y          (y),
    .smem_off   (smem_off),
    .gmem_addr  (gmem_addr),
    .smem_addr  (smem_addr),
    .in_bounds  (in_bounds)
  );

  // cmd_ready drops combinationally with reset so nothing is accepted mid-reset
  assign cmd_ready = (state == ST_IDLE) && reset_n;
  assign busy      = (state != ST_IDLE);
  assign wr_fire   = (state == ST_WAIT_WR) && wr_req_valid && wr_req_ready;
  assign skip_evt  = (state == ST_ISSUE) && !rd_req_valid && (idx != cmd_q.total)
                     && !in_bounds && cmd_q.is_s2g;

  // request fields are zero whenever the matching valid is low
  assign rd_req_addr  = rd_req_valid ? (cmd_q.is_s2g ? smem_addr : gmem_addr) : '0;
  assign rd_req_smem  = rd_req_valid & cmd_q.is_s2g;
  assign rd_req_bytes = rd_req_valid ? cmd_q.elem_bytes : 4'd0;
  assign wr_req_addr  = wr_req_valid ? (cmd_q.is_s2g ? gmem_addr : smem_addr) : '0;
  assign wr_req_smem  = wr_req_valid & ~cmd_q.is_s2g;
  assign wr_req_bytes = wr_req_valid ? cmd_q.elem_bytes : 4'd0;
  assign wr_req_data  = wr_req_valid ? data_q : '0;

  // next tile position: x wraps at tile0 and carries into y; tile0==0 pins both
  always_comb begin
    x_nxt = 32'd0;
    y_nxt = 32'd0;
    if (cmd_q.tile0 != 32'd0) begin
      if (x + 32'd1 == cmd_q.tile0) begin
        x_nxt = 32'd0;
        y_nxt = y + 32'd1;
      end else begin
        x_nxt = x + 32'd1;
        y_nxt = y;
      end
    end
  end

  // byte-lane mask selecting the low elem_bytes bytes of a response
  always_comb begin
    rsp_mask = '0;
    for (int b = 0; b < MAX_ELEM_BYTES; b++) begin
      rsp_mask[b*8 +: 8] = (b < int'(cmd_q.elem_bytes)) ? 8'hFF : 8'h00;
    end
  end

  // transfer sequencing FSM with registered valids
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      idx          <= 32'd0;
      x            <= 32'd0;
      y            <= 32'd0;
      smem_off     <= '0;
      data_q       <= '0;
      rd_req_valid <= 1'b0;
      wr_req_valid <= 1'b0;
      done_valid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q            <= cmd_data;
            cmd_q.elem_bytes <= clamp_elem_bytes(cmd_data.elem_bytes, 4'(MAX_ELEM_BYTES));
            idx              <= 32'd0;
            x                <= 32'd0;
            y                <= 32'd0;
            smem_off         <= '0;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (rd_req_valid) begin
            if (rd_req_ready) begin
              rd_req_valid <= 1'b0;
              state        <= ST_WAIT_RD;
            end
          end else if (idx == cmd_q.total) begin
            done_valid <= 1'b1;
            state      <= ST_DONE;
          end else if (in_bounds) begin
            rd_req_valid <= 1'b1;
          end else if (!cmd_q.is_s2g) begin
            data_q       <= '0;
            wr_req_valid <= 1'b1;
            state        <= ST_WAIT_WR;
          end else begin
            idx      <= idx + 32'd1;
            x        <= x_nxt;
            y        <= y_nxt;
            smem_off <= smem_off + ADDR_WIDTH'(cmd_q.elem_bytes);
          end
        end
        ST_WAIT_RD: begin
          if (rd_rsp_valid) begin
            data_q       <= rd_rsp_data & rsp_mask;
            wr_req_valid <= 1'b1;
            state        <= ST_WAIT_WR;
          end
        end
        ST_WAIT_WR: begin
          if (wr_req_ready) begin
            wr_req_valid <= 1'b0;
            idx          <= idx + 32'd1;
            x            <= x_nxt;
            y            <= y_nxt;
            smem_off     <= smem_off + ADDR_WIDTH'(cmd_q.elem_bytes);
            state        <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TMA_XFER_PERF_EN
  logic [31:0] elems_q, oob_q;
  logic        oob_evt;

  assign oob_evt    = (state == ST_ISSUE) && !rd_req_valid && (idx != cmd_q.total) && !in_bounds;
  assign perf_elems = elems_q;
  assign perf_oob   = oob_q;

  // saturating element / out-of-bounds counters, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elems_q <= 32'd0;
      oob_q   <= 32'd0;
    end else begin
      if ((wr_fire || skip_evt) && (elems_q != 32'hFFFF_FFFF)) elems_q <= elems_q + 32'd1;
      if (oob_evt && (oob_q != 32'hFFFF_FFFF)) oob_q <= oob_q + 32'd1;
    end
  end
`else
  assign perf_elems = 32'd0;
  assign perf_oob   = 32'd0;
`endif

endmodule

// File: tb/tb_vx_tma_xfer_ctrl.sv
// Self-checking bench for vx_tma_xfer_ctrl: directed tile scenarios followed by
// randomized commands, checked against a per-element reference model.
module tb_vx_tma_xfer_ctrl;
  import vx_tma_xfer_ctrl_pkg::*;

  localparam int AW  = 32;
  localparam int MEB = 8;
  localparam int DW  = MEB * 8;

  logic          clk, reset_n;
  logic          cmd_valid, cmd_ready;
  tma_xfer_cmd_t cmd_data;
  logic          rd_req_valid, rd_req_ready, rd_req_smem;
  logic [AW-1:0] rd_req_addr;
  logic [3:0]    rd_req_bytes;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic          wr_req_valid, wr_req_ready, wr_req_smem;
  logic [AW-1:0] wr_req_addr;
  logic [3:0]    wr_req_bytes;
  logic [DW-1:0] wr_req_data;
  logic          done_valid, done_ready, busy;
  logic [31:0]   perf_elems, perf_oob;

  vx_tma_xfer_ctrl #(.ADDR_WIDTH(AW), .MAX_ELEM_BYTES(MEB)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_smem(rd_req_smem), .rd_req_bytes(rd_req_bytes),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_smem(wr_req_smem), .wr_req_bytes(wr_req_bytes), .wr_req_data(wr_req_data),
    .done_valid(done_valid), .done_ready(done_ready), .busy(busy),
    .perf_elems(perf_elems), .perf_oob(perf_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic smem; } rd_exp_t;
  typedef struct { logic [31:0] addr; logic smem; logic from_rd; } wr_exp_t;

  rd_exp_t     rd_q[$];
  wr_exp_t     wr_q[$];
  logic [63:0] data_q[$];
  longint      exp_perf_elems, exp_perf_oob;
  int          tests, fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [3:0] eb);
    logic [63:0] m;
    int n;
    n = int'(eb);
    m = (n >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (n * 8)) - 64'd1);
    return d & m;
  endfunction

  // Reference: element i sits at (i mod tile0, i div tile0) within the tile.
  task automatic build_model(input tma_xfer_cmd_t c, output int n_rd, output int n_wr,
                             output int n_skip, output int n_oob);
    logic [31:0] xx, yy, i0, i1, ga, sa, eb;
    rd_exp_t re;
    wr_exp_t we;
    rd_q.delete(); wr_q.delete(); data_q.delete();
    n_rd = 0; n_wr = 0; n_skip = 0; n_oob = 0;
    eb = (c.elem_bytes > 4'd8) ? 32'd8 : {28'd0, c.elem_bytes};
    for (logic [31:0] i = 0; i < c.total; i++) begin
      xx = (c.tile0 == 0) ? 32'd0 : i % c.tile0;
      yy = (c.tile0 == 0) ? 32'd0 : i / c.tile0;
      i0 = c.coord0 + xx;
      i1 = c.coord1 + yy;
      ga = c.gbase + i0 * eb + i1 * c.stride0;
      sa = c.smem_base + i * eb;
      if (i0 < c.size0 && i1 < c.size1) begin
        re.addr = c.is_s2g ? sa : ga;  re.smem = c.is_s2g;
        we.addr = c.is_s2g ? ga : sa;  we.smem = !c.is_s2g; we.from_rd = 1'b1;
        rd_q.push_back(re); wr_q.push_back(we);
        n_rd++; n_wr++;
      end else begin
        n_oob++;
        if (!c.is_s2g) begin
          we.addr = sa; we.smem = 1'b1; we.from_rd = 1'b0;
          wr_q.push_back(we);
          n_wr++;
        end else n_skip++;
      end
    end
  endtask

  task automatic chk_perf();
`ifdef TMA_XFER_PERF_EN
    chk("perf_elems", perf_elems, exp_perf_elems);
    chk("perf_oob", perf_oob, exp_perf_oob);
`else
    chk("perf_elems_off", perf_elems, 0);
    chk("perf_oob_off", perf_oob, 0);
`endif
  endtask

  // Runs one command from accept to done (or aborts with reset at abort_at).
  task automatic run_cmd(input tma_xfer_cmd_t c, input int hold, input int stall_pct,
                         input int done_hold, input int abort_at);
    int n_rd, n_wr, n_skip, n_oob, cyc, budget, rd_wait, wr_wait, rsp_cnt, done_cnt, got_rd, got_wr;
    logic rd_pend, wr_pend, outstanding, got_done, acc;
    logic [31:0] rd_addr_p, wr_addr_p;
    logic [63:0] wr_data_p, rsp_val, dexp;
    logic [3:0] ebc;
    rd_exp_t re;
    wr_exp_t we;
    build_model(c, n_rd, n_wr, n_skip, n_oob);
    ebc = (c.elem_bytes > 4'd8) ? 4'd8 : c.elem_bytes;
    @(negedge clk);
    cmd_data = c; cmd_valid = 1'b1; acc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (cmd_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    chk("cmd_accept", acc, 1);
    if (!acc) begin cmd_valid = 1'b0; return; end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = '1;
    chk("busy_after_accept", busy, 1);
    chk("cmd_ready_while_busy", cmd_ready, 0);
    rd_pend = 0; wr_pend = 0; outstanding = 0; got_done = 0;
    rd_wait = 0; wr_wait = 0; rsp_cnt = 0; done_cnt = 0; got_rd = 0; got_wr = 0;
    rd_addr_p = 0; wr_addr_p = 0; wr_data_p = 0;
    budget = int'(c.total) * 40 + done_hold + 50;
    cyc = 0;
    while (!got_done && cyc < budget) begin
      if (abort_at > 0 && cyc == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_rd_valid", rd_req_valid, 0);
        chk("rst_wr_valid", wr_req_valid, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rd_addr", rd_req_addr, 0);
        chk("rst_wr_addr", wr_req_addr, 0);
        chk("rst_wr_smem", wr_req_smem, 0);
        chk("rst_perf_elems", perf_elems, 0);
        chk("rst_perf_oob", perf_oob, 0);
        rd_req_ready = 0; wr_req_ready = 0; rd_rsp_valid = 0; done_ready = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        exp_perf_elems = 0; exp_perf_oob = 0;
        repeat (3) begin
          @(negedge clk);
          chk("no_done_after_abort", done_valid, 0);
        end
        chk("idle_after_abort", cmd_ready, 1);
        return;
      end
      rd_rsp_valid = 1'b0;
      rd_rsp_data  = {$urandom, $urandom};
      if (outstanding) begin
        if (rsp_cnt == 0) begin
          rsp_val = {$urandom, $urandom};
          rd_rsp_valid = 1'b1; rd_rsp_data = rsp_val;
          data_q.push_back(mask_bytes(rsp_val, ebc));
          outstanding = 1'b0;
        end else rsp_cnt--;
      end else if ($urandom_range(0, 3) == 0) begin
        rd_rsp_valid = 1'b1;
      end
      if (rd_req_valid) begin
        if (!rd_pend) begin
          got_rd++;
          if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
          else begin
            re = rd_q.pop_front();
            chk("rd_addr", rd_req_addr, re.addr);
            chk("rd_smem", rd_req_smem, re.smem);
            chk("rd_bytes", rd_req_bytes, ebc);
          end
          rd_pend = 1'b1; rd_wait = 0; rd_addr_p = rd_req_addr;
        end else chk("rd_addr_stable", rd_req_addr, rd_addr_p);
        if (rd_wait >= hold && $urandom_range(0, 99) >= stall_pct) begin
          rd_req_ready = 1'b1; rd_pend = 1'b0; outstanding = 1'b1; rsp_cnt = $urandom_range(0, 3);
        end else begin
          rd_req_ready = 1'b0; rd_wait++;
        end
      end else begin
        if (rd_pend) chk("rd_valid_dropped", 0, 1);
        rd_pend = 1'b0;
        rd_req_ready = 1'($urandom_range(0, 1));
      end
      if (wr_req_valid) begin
        if (!wr_pend) begin
          got_wr++;
          if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            we = wr_q.pop_front();
            dexp = 64'd0;
            if (we.from_rd) begin
              if (data_q.size() == 0) chk("wr_without_rsp", 1, 0);
              else dexp = data_q.pop_front();
            end
            chk("wr_addr", wr_req_addr, we.addr);
            chk("wr_smem", wr_req_smem, we.smem);
            chk("wr_bytes", wr_req_bytes, ebc);
            chk("wr_data", wr_req_data, dexp);
          end
          wr_pend = 1'b1; wr_wait = 0; wr_addr_p = wr_req_addr; wr_data_p = wr_req_data;
        end else begin
          chk("wr_addr_stable", wr_req_addr, wr_addr_p);
          chk("wr_data_stable", wr_req_data, wr_data_p);
        end
        if (wr_wait >= hold && $urandom_range(0, 99) >= stall_pct) begin
          wr_req_ready = 1'b1; wr_pend = 1'b0;
        end else begin
          wr_req_ready = 1'b0; wr_wait++;
        end
      end else begin
        if (wr_pend) chk("wr_valid_dropped", 0, 1);
        wr_pend = 1'b0;
        wr_req_ready = 1'($urandom_range(0, 1));
      end
      done_ready = 1'b0;
      if (done_valid) begin
        chk("ready_done_excl", cmd_ready, 0);
        if (done_cnt == 0) begin
          chk("done_rd_count", got_rd, n_rd);
          chk("done_wr_count", got_wr, n_wr);
          if (c.total == 0) chk("done_latency", cyc, 1);
        end else chk("busy_while_done_held", busy, 1);
        if (done_cnt >= done_hold) begin
          done_ready = 1'b1; got_done = 1'b1;
        end
        done_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    rd_req_ready = 0; wr_req_ready = 0; done_ready = 0; rd_rsp_valid = 0;
    chk("done_fired", got_done, 1);
    chk("done_dropped", done_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    exp_perf_elems += n_wr + n_skip;
    exp_perf_oob   += n_oob;
    chk_perf();
  endtask

  tma_xfer_cmd_t c36, c37, c38, c39, cr;

  initial begin
    tests = 0; fails = 0;
    exp_perf_elems = 0; exp_perf_oob = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_data = '0;
    wr_req_ready = 1'b0; done_ready = 1'b0;
    #1;
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd_valid", rd_req_valid, 0);
    chk("reset_wr_valid", wr_req_valid, 0);
    chk("reset_done_valid", done_valid, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk_perf();

    c36 = '0;
    c36.gbase = 32'h1000; c36.smem_base = 32'h200;
    c36.size0 = 16; c36.size1 = 16; c36.stride0 = 64;
    c36.tile0 = 4; c36.total = 8; c36.elem_bytes = 4; c36.is_s2g = 1'b0;
    run_cmd(c36, 0, 0, 0, 0);

    c37 = c36; c37.coord0 = 14; c37.total = 4;
    run_cmd(c37, 0, 0, 0, 0);

    c38 = c37; c38.is_s2g = 1'b1;
    run_cmd(c38, 0, 20, 1, 0);

    c39 = c36; c39.total = 0;
    run_cmd(c39, 0, 0, 5, 0);

    run_cmd(c36, 3, 0, 0, 0);
    run_cmd(c36, 1, 0, 0, 6);
    run_cmd(c36, 0, 30, 2, 0);

    for (int n = 0; n < 25; n++) begin
      cr = '0;
      cr.gbase      = $urandom;
      cr.smem_base  = $urandom;
      cr.tile0      = $urandom_range(0, 5);
      cr.total      = $urandom_range(0, 12);
      cr.size0      = $urandom_range(0, 8);
      cr.size1      = $urandom_range(0, 6);
      cr.coord0     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 8));
      cr.coord1     = $urandom_range(0, 6);
      cr.stride0    = $urandom;
      cr.elem_bytes = 4'($urandom_range(1, 15));
      cr.is_s2g     = 1'($urandom_range(0, 1));
      run_cmd(cr, $urandom_range(0, 2), $urandom_range(0, 50), $urandom_range(0, 3), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
